// File: rtl/enc_line_trig.sv
// Quadrature encoder front end: differential qualify, glitch filter, x4 decode,
// backlash-suppressed line trigger divider. Optional ENC_PERIOD_EN adds trigger period measurement.
module enc_line_trig #(
  parameter int FILT_LEN = 4,
  parameter int POS_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_enc_p,
  input  logic [2:0]       i_enc_n,
  input  logic             i_en,
  input  logic [7:0]       i_div,
  input  logic             i_dir_sel,
  output logic             o_line_trig,
  output logic             o_dir,
  output logic [POS_W-1:0] o_pos,
  output logic             o_err,
  output logic [23:0]      o_period,
  output logic             o_period_vld
);

  localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

  // Next {B,A} state in the 00->01->11->10 rotation
  function automatic logic [1:0] fwd_next(input logic [1:0] ba);
    logic [1:0] nxt;
    case (ba)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      2'b10:   nxt = 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  logic [2:0]      r_p_s1, r_p_s2, r_n_s1, r_n_s2;
  logic [2:0]      r_cand, r_filt, r_vld;
  logic [2:0][3:0] r_fcnt;
  logic [1:0]      r_ref;
  logic            r_init;
  logic            r_z_prev, r_z_vld_d;
  logic [7:0]      r_step_cnt;
  logic [POS_W-1:0] r_deficit;

  logic [2:0] w_fault;
  logic [1:0] w_ba, w_delta;
  logic       w_chg, w_adj, w_illegal, w_fwd, w_rev, w_count, w_hit, w_trig, w_z_rise;
  logic [7:0] w_div_eff, w_cnt_inc;

  // Two-stage synchronizers; N resets high so the idle state is not a fault
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_s1 <= 3'b000;
      r_p_s2 <= 3'b000;
      r_n_s1 <= 3'b111;
      r_n_s2 <= 3'b111;
    end else begin
      r_p_s1 <= i_enc_p;
      r_p_s2 <= r_p_s1;
      r_n_s1 <= i_enc_n;
      r_n_s2 <= r_n_s1;
    end
  end

  assign w_fault = ~(r_p_s2 ^ r_n_s2);

  // Per-channel stability filter; r_vld marks the first accepted value after reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cand <= 3'b000;
      r_filt <= 3'b000;
      r_vld  <= 3'b000;
      r_fcnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_fault[i]) begin
          r_fcnt[i] <= r_fcnt[i];
        end else if (r_vld[i] && (r_p_s2[i] == r_filt[i])) begin
          r_cand[i] <= r_filt[i];
          r_fcnt[i] <= 4'd0;
        end else if (r_p_s2[i] != r_cand[i]) begin
          r_cand[i] <= r_p_s2[i];
          r_fcnt[i] <= 4'd0;
        end else if (r_fcnt[i] == CNT_MAX) begin
          r_filt[i] <= r_cand[i];
          r_vld[i]  <= 1'b1;
          r_fcnt[i] <= 4'd0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  // Step classification and trigger decision
  always_comb begin
    w_ba      = r_filt[1:0];
    w_delta   = w_ba ^ r_ref;
    w_chg     = !r_init && (w_delta != 2'b00);
    w_illegal = w_chg && (w_delta == 2'b11);
    w_adj     = w_chg && (w_delta != 2'b11);
    w_fwd     = w_adj && ((w_ba == fwd_next(r_ref)) ^ i_dir_sel);
    w_rev     = w_adj && !w_fwd;
    w_div_eff = (i_div == 8'd0) ? 8'd1 : i_div;
    w_cnt_inc = r_step_cnt + 8'd1;
    w_count   = w_fwd && (r_deficit == {POS_W{1'b0}});
    w_hit     = w_count && (w_cnt_inc >= w_div_eff);
    w_trig    = w_hit && i_en;
    w_z_rise  = r_filt[2] && !r_z_prev && r_z_vld_d;
  end

  // Decode state, position, backlash deficit and trigger output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref       <= 2'b00;
      r_init      <= 1'b1;
      r_z_prev    <= 1'b0;
      r_z_vld_d   <= 1'b0;
      r_step_cnt  <= 8'd0;
      r_deficit   <= {POS_W{1'b0}};
      o_line_trig <= 1'b0;
      o_dir       <= 1'b0;
      o_pos       <= {POS_W{1'b0}};
      o_err       <= 1'b0;
    end else begin
      o_line_trig <= w_trig;
      r_z_prev    <= r_filt[2];
      r_z_vld_d   <= r_vld[2];
      if ((|w_fault) || w_illegal) begin
        o_err <= 1'b1;
      end
      if (r_init && r_vld[0] && r_vld[1]) begin
        r_ref  <= w_ba;
        r_init <= 1'b0;
      end else if (w_chg) begin
        r_ref <= w_ba;
      end
      if (w_fwd) begin
        o_dir <= 1'b1;
        if (r_deficit != {POS_W{1'b0}}) begin
          r_deficit <= r_deficit - POS_W'(1);
        end else if (w_hit) begin
          r_step_cnt <= 8'd0;
        end else begin
          r_step_cnt <= w_cnt_inc;
        end
      end else if (w_rev) begin
        o_dir <= 1'b0;
        if (r_deficit != {POS_W{1'b1}}) begin
          r_deficit <= r_deficit + POS_W'(1);
        end
      end
      // Index wins over a coincident step
      if (w_z_rise) begin
        o_pos <= {POS_W{1'b0}};
      end else if (w_fwd) begin
        o_pos <= o_pos + POS_W'(1);
      end else if (w_rev) begin
        o_pos <= o_pos - POS_W'(1);
      end
    end
  end

`ifdef ENC_PERIOD_EN
  logic [23:0] r_per_cnt;
  logic        r_per_armed;

  // Trigger-to-trigger period; the first trigger after reset only starts the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_per_cnt    <= 24'd0;
      r_per_armed  <= 1'b0;
      o_period     <= 24'd0;
      o_period_vld <= 1'b0;
    end else begin
      o_period_vld <= 1'b0;
      if (w_trig) begin
        r_per_cnt   <= 24'd0;
        r_per_armed <= 1'b1;
        if (r_per_armed) begin
          o_period     <= (r_per_cnt == 24'hFFFFFF) ? r_per_cnt : r_per_cnt + 24'd1;
          o_period_vld <= 1'b1;
        end
      end else if (r_per_cnt != 24'hFFFFFF) begin
        r_per_cnt <= r_per_cnt + 24'd1;
      end
    end
  end
`else
  assign o_period     = 24'd0;
  assign o_period_vld = 1'b0;
`endif

endmodule

// File: doc/enc_line_trig.md
# enc_line_trig

Quadrature encoder front end for the line scanner. It sits between the differential encoder pins (ENC_P/ENC_N) and the sensor sequencer that drives SIC. It qualifies and filters the A/B/Z channels and decodes them x4 into a position count. It then issues one single-cycle LINE_TRIG every DIV forward steps, with reverse-motion backlash suppression, so that each scanned line maps to a fixed mechanical pitch.

## Interface
- FILT_LEN, 4: consecutive stable CLK cycles required before a channel value is accepted (2..15)
- POS_W, 16: width of POS and of the backlash deficit counter

- CLK  in  1  system clock (sequencer domain)
- RST  in  1  synchronous, active-high reset
- ENC_P  in  3  encoder positive lines; bit0 = A, bit1 = B, bit2 = Z (index)
- ENC_N  in  3  encoder negative lines, complement of ENC_P
- EN  in  1  trigger enable; decode and POS run regardless
- DIV  in  8  forward steps per line trigger; 0 is treated as 1
- DIR_SEL  in  1  0: the {B,A} sequence 00→01→11→10 is forward; 1: the reverse sequence is forward
- LINE_TRIG  out  1  one-cycle trigger pulse to the sequencer
- DIR  out  1  direction of the last valid step (1 = forward)
- POS  out  POS_W  signed position, ±1 per valid step, wraps
- ERR  out  1  sticky: illegal quadrature transition or differential fault seen
- PERIOD  out  24  CLK cycles between the last two LINE_TRIGs (ENC_PERIOD_EN)
- PERIOD_VLD  out  1  one-cycle pulse when PERIOD updates (ENC_PERIOD_EN)

## Operation
- Input stage, per channel: a 2-FF synchronizer on both P and N.
  - If the synchronized P equals N, it is a differential fault: ERR is set and the filter counter for that channel holds.
  - Otherwise the candidate value is P. The filtered value takes the candidate after it has been stable for FILT_LEN consecutive cycles.
- Init: the first filtered {B,A} after reset is loaded as the reference without counting a step (init flag).
- Decode, on a change of filtered {B,A}:
  - A Gray-adjacent change is one step. POS is incremented or decremented, and DIR is updated.
  - A two-bit change sets ERR. No step is counted and the reference is updated.
- Backlash:
  - A reverse step increments the deficit counter, which saturates at all-ones.
  - A forward step with deficit ≠ 0 decrements the deficit and is not counted toward a trigger.
  - A forward step with deficit = 0 increments the step counter.
- Trigger:
  - When the step counter reaches DIV_eff, it clears to 0. If EN = 1, LINE_TRIG pulses; if EN = 0, the step is absorbed and no pulse is issued.
  - A DIV change takes effect at the next comparison. If the counter is already ≥ the new DIV_eff, the next counted step triggers.
- Index: a rising edge of filtered Z clears POS to 0. This overrides a step in the same cycle. The step and backlash counters are untouched.
- ERR clears only on RST.

## Timing
- Reset values:
  - LINE_TRIG, DIR, POS, ERR, PERIOD and PERIOD_VLD are 0.
  - The step counter, deficit, filter counters and PERIOD counter are 0, and the init flag is set.
- Latency: with a clean input edge at cycle 0, the filtered value changes at cycle 2+FILT_LEN. POS, DIR and LINE_TRIG update at 3+FILT_LEN.
- Pulses narrower than FILT_LEN cycles are rejected completely.
- At most one step is decoded per cycle, so the maximum step rate is CLK/(FILT_LEN+1).
- RST mid-operation aborts any pending filter count. No LINE_TRIG is issued in the reset cycle or the cycle after it.

## Configuration
- ENC_PERIOD_EN defined:
  - A 24-bit counter runs on every CLK cycle, saturating at 0xFFFFFF.
  - On each LINE_TRIG cycle, PERIOD takes the counter value plus 1 (saturating), PERIOD_VLD pulses in the same cycle, and the counter clears.
  - The first LINE_TRIG after reset only clears the counter and produces no PERIOD_VLD.
- ENC_PERIOD_EN undefined: PERIOD = 0 and PERIOD_VLD = 0 permanently, and no counter is synthesized.

## Test plan
- Forward stream: DIV=1, DIR_SEL=0, EN=1, A/B toggled alternately every 2857 CLK (700 pps).
  - Required: LINE_TRIG every 2857 cycles, DIR=1, POS +1 per edge.
  - With ENC_PERIOD_EN defined: PERIOD=2857 from the second trigger onward.
- Divider: DIV=4, 16 forward steps → exactly 4 LINE_TRIGs, each on the 4th, 8th, 12th and 16th step. DIV=0 → one trigger per step.
- Backlash: 5 forward, 3 reverse, 5 forward, with DIV=1.
  - Required: 5+2 = 7 LINE_TRIGs, POS=7, no trigger during the reverse or first 3 re-forward steps.
- Glitch and fault:
  - A 2-cycle pulse on A with FILT_LEN=4 → no POS change, ERR=0.
  - ENC_P[0]=ENC_N[0] held for 10 cycles → ERR=1, POS unchanged.
  - {B,A} 00→11 held stable → ERR=1, no step.
- Index and enable:
  - A Z rising edge at POS=37 → POS=0 at 3+FILT_LEN cycles.
  - EN=0 during 10 steps → POS=10, no LINE_TRIG.
  - RST asserted mid-stream → all outputs 0 on the next cycle.
